// File: rtl/obb_update_scheduler_if.sv
// Host access bus between the CPU bridge and the OBB update scheduler.
// Latency: grant is combinational; read data returns one cycle after grant.
// Backpressure: an ungranted request is held by the master until host_gnt.
//
// Ports (master = host bridge, slave = scheduler):
//   host_req/host_we/host_addr/host_wdata  master -> slave request
//   host_gnt                               slave -> master, access taken this cycle
//   host_rvalid/host_rdata                 slave -> master, read return
interface obb_update_scheduler_if #(
  parameter int ADDR_W = 4,
  parameter int OBB_W  = 166
);
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [OBB_W-1:0]  host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [OBB_W-1:0]  host_rdata;

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata
  );

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata
  );
endinterface

// File: rtl/obb_update_scheduler.sv
// Sweeps the OBB updater over object-state RAM slots each frame tick; host shares the RAM port.
// Latency: 3 cycles per slot (READ/LATCH/WRITE), sweep_done at cycle 3N+1 after the tick.
// Backpressure: host requests are granted only in IDLE without a tick; otherwise held by host.
//
// Ports: clk, reset_n (sync, active-low); frame_tick/obj_count start a sweep;
//   ram_addr/ram_we/ram_wdata/ram_rdata drive the single-port state RAM (1-cycle read);
//   upd_prev/upd_next connect the combinational obb_updater; host = host bus (slave modport);
//   busy, sweep_done, overrun (sticky, cleared by overrun_clr).
// Optional: define OBB_SCHED_OVERRUN_CNT_EN to add overrun_cnt[15:0], a saturating
//   count of ignored frame ticks.
module obb_update_scheduler #(
  parameter int ADDR_W = 4,
  parameter int OBB_W  = 166
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  frame_tick,
  input  logic [ADDR_W:0]       obj_count,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic                  ram_we,
  output logic [OBB_W-1:0]      ram_wdata,
  input  logic [OBB_W-1:0]      ram_rdata,
  output logic [OBB_W-1:0]      upd_prev,
  input  logic [OBB_W-1:0]      upd_next,
  obb_update_scheduler_if.slave host,
  output logic                  busy,
  output logic                  sweep_done,
  output logic                  overrun,
  input  logic                  overrun_clr
`ifdef OBB_SCHED_OVERRUN_CNT_EN
  ,
  output logic [15:0]           overrun_cnt
`endif
);

  localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_CNT = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LATCH = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W:0]   r_cnt;
  logic [OBB_W-1:0]  r_prev_q;
  logic              r_overrun;
  logic              r_host_rvalid;
  logic [OBB_W-1:0]  r_host_rdata;

  logic              w_tick_start;
  logic              w_tick_ignored;
  logic              w_last;
  logic              w_host_gnt;
  logic              w_ram_we_raw;
  logic [ADDR_W:0]   w_cnt_clamp;

  assign w_tick_start   = (r_state == S_IDLE) && frame_tick;
  assign w_tick_ignored = (r_state != S_IDLE) && frame_tick;
  assign w_cnt_clamp    = (obj_count > MAX_CNT) ? MAX_CNT : obj_count;
  // r_cnt is never 0 while in WRITE, so the subtraction cannot wrap there.
  assign w_last         = ({1'b0, r_idx} == (r_cnt - ONE_CNT));
  // Grant is also masked during reset so a host write cannot slip through.
  assign w_host_gnt     = reset_n && (r_state == S_IDLE) && host.host_req && !frame_tick;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (frame_tick) begin
          w_state_nxt = (w_cnt_clamp == '0) ? S_DONE : S_READ;
        end
      end
      S_READ:  w_state_nxt = S_LATCH;
      S_LATCH: w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = w_last ? S_DONE : S_READ;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ram_addr     = '0;
    w_ram_we_raw = 1'b0;
    ram_wdata    = '0;
    busy         = 1'b0;
    sweep_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_host_gnt) begin
          ram_addr     = host.host_addr;
          w_ram_we_raw = host.host_we;
          ram_wdata    = host.host_wdata;
        end
      end
      S_READ: begin
        ram_addr = r_idx;
        busy     = 1'b1;
      end
      S_LATCH: begin
        busy = 1'b1;
      end
      S_WRITE: begin
        ram_addr     = r_idx;
        w_ram_we_raw = 1'b1;
        ram_wdata    = upd_next;
        busy         = 1'b1;
      end
      S_DONE: begin
        busy       = 1'b1;
        sweep_done = 1'b1;
      end
      default: ;
    endcase
  end

  // The state register only changes at the edge, so gate the strobe
  // combinationally to keep a mid-sweep reset cycle from writing.
  assign ram_we = w_ram_we_raw & reset_n;

  // Sweep datapath: slot index, latched count, captured previous state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_idx    <= '0;
      r_cnt    <= '0;
      r_prev_q <= '0;
    end else begin
      if (w_tick_start) begin
        r_cnt <= w_cnt_clamp;
        r_idx <= '0;
      end
      if (r_state == S_LATCH) begin
        r_prev_q <= ram_rdata;
      end
      if ((r_state == S_WRITE) && !w_last) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // Sticky overrun: a set in the same cycle as a clear wins
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_overrun <= 1'b0;
    end else if (w_tick_ignored) begin
      r_overrun <= 1'b1;
    end else if (overrun_clr) begin
      r_overrun <= 1'b0;
    end
  end

  // Host read return: RAM data arrives the cycle after grant; hold it afterwards
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_host_rvalid <= 1'b0;
      r_host_rdata  <= '0;
    end else begin
      r_host_rvalid <= w_host_gnt && !host.host_we;
      if (r_host_rvalid) begin
        r_host_rdata <= ram_rdata;
      end
    end
  end

`ifdef OBB_SCHED_OVERRUN_CNT_EN
  logic [15:0] r_overrun_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_overrun_cnt <= '0;
    end else if (w_tick_ignored) begin
      if (overrun_clr) begin
        r_overrun_cnt <= 16'd1;
      end else if (r_overrun_cnt != 16'hFFFF) begin
        r_overrun_cnt <= r_overrun_cnt + 16'd1;
      end
    end else if (overrun_clr) begin
      r_overrun_cnt <= '0;
    end
  end

  assign overrun_cnt = r_overrun_cnt;
`endif

  assign upd_prev         = r_prev_q;
  assign overrun          = r_overrun;
  assign host.host_gnt    = w_host_gnt;
  assign host.host_rvalid = r_host_rvalid;
  assign host.host_rdata  = r_host_rvalid ? ram_rdata : r_host_rdata;

endmodule

// File: tb/tb_obb_update_scheduler.sv
// Bench for obb_update_scheduler: behavioural RAM + updater, schedule-based reference model.
// Latency: model predicts every output per cycle from tick time and slot count.
// Backpressure: host tasks hold requests until granted, bounded by a cycle budget.
module tb_obb_update_scheduler;
  localparam int AW = 4;
  localparam int OW = 166;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          frame_tick;
  logic [AW:0]   obj_count;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [OW-1:0] ram_wdata;
  logic [OW-1:0] ram_rdata;
  logic [OW-1:0] upd_prev;
  logic [OW-1:0] upd_next;
  logic          busy;
  logic          sweep_done;
  logic          overrun;
  logic          overrun_clr;
`ifdef OBB_SCHED_OVERRUN_CNT_EN
  logic [15:0]   overrun_cnt;
`endif

  obb_update_scheduler_if #(.ADDR_W(AW), .OBB_W(OW)) hif ();

  obb_update_scheduler #(.ADDR_W(AW), .OBB_W(OW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .obj_count  (obj_count),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .upd_prev   (upd_prev),
    .upd_next   (upd_next),
    .host       (hif),
    .busy       (busy),
    .sweep_done (sweep_done),
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
`ifdef OBB_SCHED_OVERRUN_CNT_EN
    ,
    .overrun_cnt(overrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chki(input string nm, input int a, input int e);
    n_cmp++;
    if (a != e) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d (0x%0h) expected %0d (0x%0h)", nm, cyc, a, a, e, e);
    end
  endtask

  task automatic chkw(input string nm, input logic [OW-1:0] a, input logic [OW-1:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, a, e);
    end
  endtask

  // pos_x occupies bits [149:118]: width/height take the top 16 bits
  function automatic logic [OW-1:0] inc_posx(input logic [OW-1:0] v);
    logic [OW-1:0] r;
    r = v;
    r[149:118] = v[149:118] + 32'd1;
    return r;
  endfunction

  function automatic logic [OW-1:0] make_obb(input int k);
    return {8'(k + 1), 8'(k + 2), 32'(32'h1000 + k), 32'(32'h2000 + k),
            32'(32'h3000 + k), 32'(32'h4000 + k), 11'(3 * k), 11'(5 * k)};
  endfunction

  // Environment: combinational updater, registered single-port RAM
  assign upd_next = inc_posx(upd_prev);

  logic [OW-1:0] mem [16];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // Reference model: a sweep accepted at cycle t0 with N slots reads slot k at
  // t0+3k+1, writes it at t0+3k+3, and finishes at t0+3N+1 (t0+1 for N=0).
  logic [OW-1:0] gold [16];
  bit            m_active  = 1'b0;
  int            m_t0      = 0;
  int            m_end     = 0;
  bit            m_ovr     = 1'b0;
  bit            m_rv_pend = 1'b0;
  logic [OW-1:0] m_rv_data = '0;
  logic [OW-1:0] m_rdata   = '0;
  int            m_ocnt    = 0;

  always @(negedge clk) begin : model_cmp
    bit            in_sw;
    bit            e_gnt;
    bit            e_we;
    bit            e_rd;
    bit            e_set;
    int            k;
    int            n;
    int            e_addr;
    logic [OW-1:0] e_wd;
    if (!reset_n) begin
      chki("we_in_reset", int'(ram_we), 0);
      m_active  = 1'b0;
      m_ovr     = 1'b0;
      m_rv_pend = 1'b0;
      m_rdata   = '0;
      m_ocnt    = 0;
    end else begin
      in_sw  = m_active && (cyc > m_t0) && (cyc <= m_end);
      e_we   = 1'b0;
      e_rd   = 1'b0;
      e_addr = 0;
      e_wd   = '0;
      e_gnt  = !in_sw && hif.host_req && !frame_tick;
      if (in_sw && (cyc < m_end) && ((cyc - m_t0) % 3 == 1)) begin
        e_rd   = 1'b1;
        e_addr = (cyc - m_t0 - 1) / 3;
      end
      if (in_sw && (cyc < m_end) && ((cyc - m_t0) % 3 == 0)) begin
        k      = (cyc - m_t0) / 3 - 1;
        e_we   = 1'b1;
        e_addr = k;
        e_wd   = inc_posx(gold[k]);
        chkw("upd_prev", upd_prev, gold[k]);
      end
      if (e_gnt) begin
        e_we   = hif.host_we;
        e_addr = int'(hif.host_addr);
        e_wd   = hif.host_wdata;
      end
      chki("busy", int'(busy), int'(in_sw));
      chki("sweep_done", int'(sweep_done), int'(in_sw && (cyc == m_end)));
      chki("host_gnt", int'(hif.host_gnt), int'(e_gnt));
      chki("ram_we", int'(ram_we), int'(e_we));
      chki("overrun", int'(overrun), int'(m_ovr));
      if (e_we || e_rd || e_gnt) chki("ram_addr", int'(ram_addr), e_addr);
      if (e_we) chkw("ram_wdata", ram_wdata, e_wd);
      chki("host_rvalid", int'(hif.host_rvalid), int'(m_rv_pend));
      if (m_rv_pend) m_rdata = m_rv_data;
      chkw("host_rdata", hif.host_rdata, m_rdata);
`ifdef OBB_SCHED_OVERRUN_CNT_EN
      chki("overrun_cnt", int'(overrun_cnt), m_ocnt);
`endif
      // advance model to next cycle
      if (e_we) gold[e_addr] = e_wd;
      m_rv_pend = e_gnt && !hif.host_we;
      m_rv_data = gold[int'(hif.host_addr)];
      e_set = in_sw && frame_tick;
      if (!in_sw && frame_tick) begin
        n        = (int'(obj_count) > 16) ? 16 : int'(obj_count);
        m_active = 1'b1;
        m_t0     = cyc;
        m_end    = (n == 0) ? cyc + 1 : cyc + 3 * n + 1;
      end
      if (e_set) m_ovr = 1'b1;
      else if (overrun_clr) m_ovr = 1'b0;
      if (e_set) m_ocnt = overrun_clr ? 1 : ((m_ocnt == 65535) ? 65535 : m_ocnt + 1);
      else if (overrun_clr) m_ocnt = 0;
    end
  end

  // Event recorder for the hand-computed per-scenario expectations
  int busy_cnt = 0;
  int done_q[$];
  int wr_q[$];
  always @(negedge clk) begin
    if (reset_n) begin
      if (busy) busy_cnt++;
      if (sweep_done) done_q.push_back(cyc);
      if (ram_we && !hif.host_gnt) wr_q.push_back(int'(ram_addr));
    end
  end

  function automatic int done_ofs(input int t0);
    return (done_q.size() > 0) ? done_q[0] - t0 : -1;
  endfunction

  function automatic int wr_at(input int i);
    return (i < wr_q.size()) ? wr_q[i] : -1;
  endfunction

  function automatic int posx(input int k);
    return int'(mem[k][149:118]);
  endfunction

  task automatic clr_mon();
    busy_cnt = 0;
    done_q.delete();
    wr_q.delete();
  endtask

  task automatic wait_gnt(input string nm, output int gc);
    int n = 0;
    @(negedge clk);
    while (hif.host_gnt !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chki(nm, int'(hif.host_gnt), 1);
    gc = cyc;
  endtask

  task automatic host_write(input int a, input logic [OW-1:0] d);
    int gc;
    hif.host_req   = 1'b1;
    hif.host_we    = 1'b1;
    hif.host_addr  = AW'(a);
    hif.host_wdata = d;
    wait_gnt("host_wr_gnt", gc);
    @(posedge clk); #1;
    hif.host_req = 1'b0;
    hif.host_we  = 1'b0;
  endtask

  task automatic host_read(input int a, output logic [OW-1:0] d);
    int gc;
    hif.host_req  = 1'b1;
    hif.host_we   = 1'b0;
    hif.host_addr = AW'(a);
    wait_gnt("host_rd_gnt", gc);
    @(posedge clk); #1;
    hif.host_req = 1'b0;
    @(negedge clk);
    chki("host_rd_rvalid", int'(hif.host_rvalid), 1);
    d = hif.host_rdata;
    @(posedge clk); #1;
  endtask

  task automatic tick(input int cnt, output int t);
    obj_count  = (AW + 1)'(cnt);
    frame_tick = 1'b1;
    t          = cyc;
    clr_mon();
    @(posedge clk); #1;
    frame_tick = 1'b0;
  endtask

  task automatic busy_tick(input bit clr);
    frame_tick  = 1'b1;
    overrun_clr = clr;
    @(posedge clk); #1;
    frame_tick  = 1'b0;
    overrun_clr = 1'b0;
  endtask

  initial begin
    int            t0;
    int            gc;
    logic [OW-1:0] d;
    reset_n        = 1'b0;
    frame_tick     = 1'b0;
    obj_count      = '0;
    overrun_clr    = 1'b0;
    hif.host_req   = 1'b0;
    hif.host_we    = 1'b0;
    hif.host_addr  = '0;
    hif.host_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Reset state
    chki("rst_busy", int'(busy), 0);
    chki("rst_done", int'(sweep_done), 0);
    chki("rst_overrun", int'(overrun), 0);
    chki("rst_ram_we", int'(ram_we), 0);
    chki("rst_rvalid", int'(hif.host_rvalid), 0);
    chkw("rst_rdata", hif.host_rdata, '0);
    chkw("rst_upd_prev", upd_prev, '0);
`ifdef OBB_SCHED_OVERRUN_CNT_EN
    chki("rst_ocnt", int'(overrun_cnt), 0);
`endif

    // Preload all slots, then a direct host read-back
    for (int k = 0; k < 16; k++) host_write(k, make_obb(k));
    host_read(5, d);
    chkw("host_rd_slot5", d, make_obb(5));

    // Basic sweep of 4; obj_count moved after the tick must not matter
    tick(4, t0);
    obj_count = '0;
    repeat (18) @(posedge clk);
    #1;
    chki("basic_busy_cycles", busy_cnt, 13);
    chki("basic_done_n", done_q.size(), 1);
    chki("basic_done_cyc", done_ofs(t0), 13);
    chki("basic_wr_n", wr_q.size(), 4);
    for (int i = 0; i < 4; i++) chki("basic_wr_addr", wr_at(i), i);
    for (int k = 0; k < 4; k++) chki("basic_posx", posx(k), 32'h1001 + k);
    for (int k = 4; k < 16; k++) chkw("basic_untouched", mem[k], make_obb(k));

    // Zero count: immediate DONE, no writes
    tick(0, t0);
    repeat (5) @(posedge clk);
    #1;
    chki("zero_done_cyc", done_ofs(t0), 1);
    chki("zero_wr_n", wr_q.size(), 0);
    chki("zero_busy_cycles", busy_cnt, 1);

    // Clamp: 17 -> 16 slots
    tick(17, t0);
    repeat (54) @(posedge clk);
    #1;
    chki("clamp_wr_n", wr_q.size(), 16);
    chki("clamp_done_cyc", done_ofs(t0), 49);
    chki("clamp_last_addr", wr_at(15), 15);
    chki("clamp_posx0", posx(0), 32'h1002);
    chki("clamp_posx10", posx(10), 32'h100B);

    // Host read held across a tick: granted on first IDLE after DONE
    obj_count      = 5'd4;
    hif.host_req   = 1'b1;
    hif.host_we    = 1'b0;
    hif.host_addr  = 4'd2;
    frame_tick     = 1'b1;
    t0             = cyc;
    clr_mon();
    @(posedge clk); #1;
    frame_tick = 1'b0;
    wait_gnt("arb_gnt", gc);
    chki("arb_gnt_cyc", gc - t0, 14);
    @(posedge clk); #1;
    hif.host_req = 1'b0;
    @(negedge clk);
    chki("arb_rvalid", int'(hif.host_rvalid), 1);
    chki("arb_rdata_posx", int'(hif.host_rdata[149:118]), 32'h1005);
    @(posedge clk); #1;

    // Overrun: busy tick at +5, clear+tick at +8
    repeat (2) @(posedge clk);
    #1;
    tick(4, t0);
    repeat (4) @(posedge clk);
    #1;
    busy_tick(1'b0);
    chki("ovr_set", int'(overrun), 1);
    repeat (2) @(posedge clk);
    #1;
    busy_tick(1'b1);
    chki("ovr_set_wins", int'(overrun), 1);
    repeat (10) @(posedge clk);
    #1;
    chki("ovr_done_n", done_q.size(), 1);
    chki("ovr_done_cyc", done_ofs(t0), 13);
    chki("ovr_wr_n", wr_q.size(), 4);
`ifdef OBB_SCHED_OVERRUN_CNT_EN
    chki("ocnt_after_ovr", int'(overrun_cnt), 1);
`endif
    overrun_clr = 1'b1;
    @(posedge clk); #1;
    overrun_clr = 1'b0;
    chki("ovr_cleared", int'(overrun), 0);

    // Reset during object 2 READ (cycle 7)
    tick(4, t0);
    repeat (6) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chki("rstmid_busy", int'(busy), 0);
    chki("rstmid_wr_n", wr_q.size(), 2);
    chki("rstmid_posx0", posx(0), 32'h1005);
    chki("rstmid_posx1", posx(1), 32'h1006);
    chki("rstmid_posx2", posx(2), 32'h1006);
    chki("rstmid_posx3", posx(3), 32'h1007);
    repeat (2) @(posedge clk);
    #1;
    tick(4, t0);
    repeat (16) @(posedge clk);
    #1;
    chki("resweep_done_cyc", done_ofs(t0), 13);
    chki("resweep_wr_n", wr_q.size(), 4);
    chki("resweep_posx0", posx(0), 32'h1006);
    chki("resweep_posx2", posx(2), 32'h1007);
    chki("resweep_posx3", posx(3), 32'h1008);
    chki("resweep_posx15", posx(15), 32'h1010);

`ifdef OBB_SCHED_OVERRUN_CNT_EN
    // Saturating counter: three busy ticks, then clear with a tick
    tick(4, t0);
    @(posedge clk); #1;
    busy_tick(1'b0);
    @(posedge clk); #1;
    busy_tick(1'b0);
    @(posedge clk); #1;
    busy_tick(1'b0);
    chki("ocnt_three", int'(overrun_cnt), 3);
    repeat (2) @(posedge clk);
    #1;
    busy_tick(1'b1);
    chki("ocnt_clr_tick", int'(overrun_cnt), 1);
    repeat (6) @(posedge clk);
    #1;
`endif

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/obb_update_scheduler.md
Name: obb_update_scheduler

Overview:
- Sequences the combinational OBB next-state updater across a bank of object-state slots held in a single-port state RAM, once per frame tick.
- Reads each slot, presents it to the updater, and writes the result back.
- Arbitrates the same RAM port with a host (CPU) access port.
- Sits between the frame timing logic, the object state RAM, the `obb_updater` datapath and the host bus bridge.

Parameters:
- ADDR_W, 4, state RAM address width; maximum object count is 2^ADDR_W.
- OBB_W, 166, packed OBB state width: width[8], height[8], pos_x[32], pos_y[32], vel_x[32], vel_y[32], angle[11], omega[11], MSB first.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- frame_tick  in  1  single-cycle pulse; starts a sweep
- obj_count  in  ADDR_W+1  number of slots to update; latched at sweep start
- ram_addr  out  ADDR_W  state RAM address
- ram_we  out  1  state RAM write enable
- ram_wdata  out  OBB_W  state RAM write data
- ram_rdata  in  OBB_W  state RAM read data; registered, 1-cycle latency
- upd_prev  out  OBB_W  packed previous state to the updater
- upd_next  in  OBB_W  packed next state from the updater (combinational)
- host_req  in  1  host access request
- host_we  in  1  host write (1) / read (0)
- host_addr  in  ADDR_W  host address
- host_wdata  in  OBB_W  host write data
- host_gnt  out  1  host access granted this cycle
- host_rvalid  out  1  host read data valid
- host_rdata  out  OBB_W  host read data
- busy  out  1  sweep in progress
- sweep_done  out  1  one-cycle pulse at end of sweep
- overrun  out  1  sticky: frame_tick arrived while busy
- overrun_clr  in  1  clears overrun

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (reset_n).
- Reset values: all outputs 0; state IDLE; slot index 0; prev_q 0; latched count 0.
  - ram_we is 0 in any cycle where reset_n is 0, including reset asserted mid-sweep.
  - A sweep interrupted by reset is abandoned; already-written slots keep their new values.
- States: IDLE, READ, LATCH, WRITE, DONE.
- IDLE:
  - On frame_tick, latch cnt = min(obj_count, 2^ADDR_W) and set idx = 0.
  - Go to DONE if cnt == 0, else go to READ.
  - frame_tick has priority over host_req in the same cycle: host_gnt = 0 that cycle.
- READ: ram_addr = idx, ram_we = 0; go to LATCH.
- LATCH: prev_q <= ram_rdata; go to WRITE.
- WRITE:
  - ram_addr = idx, ram_we = 1, ram_wdata = upd_next.
  - upd_prev is driven continuously from prev_q.
  - If idx == cnt-1, go to DONE; else idx++ and go to READ.
- DONE: sweep_done = 1 for one cycle; go to IDLE.
- busy is 1 in READ, LATCH, WRITE and DONE.
- Timing: frame_tick sampled at cycle 0 → first READ at cycle 1 → last WRITE at cycle 3N → sweep_done at cycle 3N+1. For N = 0, sweep_done is at cycle 1.
- Host arbitration:
  - host_gnt = host_req only in IDLE with no frame_tick; 0 in every other state. Ungranted requests must be held by the host.
  - When granted, ram_addr = host_addr, ram_we = host_we, ram_wdata = host_wdata.
  - For a granted read, host_rvalid = 1 and host_rdata = ram_rdata on the next cycle; otherwise host_rvalid = 0 and host_rdata holds its last value.
- Overrun:
  - frame_tick while busy is ignored and sets overrun.
  - overrun_clr clears overrun; if set and clear occur in the same cycle, set wins.
- obj_count changes during a sweep have no effect until the next sweep.

Optional Feature:
- Macro: OBB_SCHED_OVERRUN_CNT_EN.
- With the macro defined:
  - Adds output overrun_cnt[15:0], reset 0.
  - Increments on every ignored frame_tick and saturates at 16'hFFFF.
  - Cleared by overrun_clr, with increment winning on the same cycle (count becomes 1).
- Without the macro: the port is absent and only the sticky overrun flag exists.

Test Plan:
- Basic sweep: ADDR_W = 4; preload slots 0–3 via the host; obj_count = 4; pulse frame_tick; updater model adds 1 to pos_x.
  - Required: busy for 13 cycles; sweep_done exactly at cycle 13.
  - Required: 4 writes to addresses 0,1,2,3 in order; each slot pos_x +1.
  - Required: slots 4–15 untouched.
- Zero and clamp: obj_count = 0 → sweep_done at cycle 1, no ram_we. obj_count = 17 → 16 writes, sweep_done at cycle 49.
- Host arbitration:
  - host_req held across a tick: host_gnt = 0 from the tick cycle through DONE; granted on the first IDLE cycle after.
  - Host read of slot 2 returns the updated value with host_rvalid one cycle after grant.
- Overrun: second frame_tick at cycle 5 of a 4-object sweep → overrun = 1, no restart, sweep_done still at cycle 13. overrun_clr and another busy tick in the same cycle → overrun stays 1.
- Reset mid-sweep: reset_n = 0 at cycle 7 (object 2 READ) → no write that cycle, busy = 0 next cycle, slots 0–1 updated, slots 2–3 unchanged. A next tick performs a full sweep.
- Overrun counter (with OBB_SCHED_OVERRUN_CNT_EN): 3 ticks while busy → overrun_cnt = 3. overrun_clr with a simultaneous busy tick → overrun_cnt = 1.
